wave_sample_gen: RTL
====================

Name: wave_sample_gen

Overview:
Sample source for the waveform combiner. It is a phase-accumulator oscillator that produces one 8-bit waveform sample every DIV clock cycles. Each sample is offered to the combiner with a done/ready handshake: done is raised with the sample held stable, and the combiner's ready acknowledges it. Two instances drive the combiner's sample1/done1 and sample2/done2 inputs.

Parameters:
DIV, 4, clock cycles per sample tick (>=2)
ACC_W, 16, phase accumulator width (>=8)

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
en  input  1  enables tick counter and sample generation
phase_inc  input  ACC_W  phase increment added per tick
wave_sel  input  2  00 square, 01 saw, 10 triangle, 11 mid-level (8'h80)
ready  input  1  combiner acknowledge; a sample is taken at an edge where done=1 and ready=1
clr_ovf  input  1  synchronous clear of the overrun flag
sample  output  8  current sample, registered
done  output  1  sample valid, registered
overrun  output  1  sticky flag: a tick occurred while the previous sample was unacknowledged

Behaviour:
- Reset is asynchronous on n_rst low. Reset values: sample=8'h00, done=0, overrun=0, phase=0, tick counter=0.
- Tick counter:
  - en=1: counts 0..DIV-1 and wraps. tick is combinational, tick = en && cnt==DIV-1.
  - en=0: counter forced to 0, no ticks, phase holds. A pending done still completes its handshake normally.
- Sample function. Let p = phase[ACC_W-1:ACC_W-8], the phase value before the increment at this tick.
  - square: p[7] ? 8'hFF : 8'h00
  - saw: p
  - triangle: p[7]==0 ? {p[6:0],1'b0} : ~{p[6:0],1'b0}
  - 11: 8'h80
  - wave_sel is sampled at the tick.
- Phase update: on every tick, phase <= phase + phase_inc, modulo 2^ACC_W (wraps silently). This happens whether or not the sample is accepted.
- Acknowledge: ack = done && ready at a clock edge.
- Events at a clock edge:
  - tick && !done: sample <= f(p); done <= 1. done and sample become visible the cycle after the tick cycle (latency 1).
  - ack && !tick: done <= 0.
  - ack && tick: the old sample is consumed and the new one is loaded. sample <= f(p), done stays 1, no overrun.
  - tick && done && !ready: sample is NOT updated and done stays 1. overrun <= 1. Phase still advances, so the dropped sample is lost rather than delayed.
- overrun stays set until clr_ovf=1 at an edge or reset. If clr_ovf and a new overrun occur at the same edge, set wins.
- sample is stable whenever done=1 and only changes at a tick. ready while done=0 is ignored.
- Reset mid-handshake: done drops immediately (asynchronously). The sample is lost and no acknowledge is expected.
- phase_inc=0: constant output level; ticks and handshakes continue.

Test Plan:
1. DIV=4, phase_inc=16'h1000, saw, en=1, ready tied 1 -> done pulses one cycle every 4 cycles; sample sequence 00,10,20,...,F0,00 (wrap). overrun stays 0.
2. Same as 1 but square -> 8 samples of 00, then 8 samples of FF, repeating.
3. Triangle, phase_inc=16'h4000 -> sample sequence 00,80,FF,7F, repeating.
4. ready held 0 after first sample (saw, inc 16'h1000) -> sample stays 00 and done stays 1; overrun=1 the cycle after the second tick. Raising ready then gives done=0 next cycle; the next tick yields sample=20 (0x10 dropped). clr_ovf pulse -> overrun=0.
5. ready asserted exactly at a tick edge while done=1 -> done stays 1, sample updates to the new value, overrun stays 0.
6. n_rst pulsed low while done=1 mid-stream; en toggled low for 10 cycles -> all outputs return to reset values asynchronously. With en=0, no done pulses occur and phase holds; sample 1 starts cleanly DIV cycles after en returns to 1.

Source files
------------

// File: rtl/wave_sample_gen.sv
// wave_sample_gen: phase-accumulator oscillator that emits one 8-bit sample
// every DIV clocks and offers it to the combiner over a done/ready handshake.
//
// Ports:
//   clk        system clock
//   n_rst      asynchronous active-low reset
//   en         enables the tick counter and sample generation
//   phase_inc  phase increment added on every tick
//   wave_sel   00 square, 01 saw, 10 triangle, 11 mid-level (8'h80)
//   ready      combiner acknowledge; a sample is taken when done && ready
//   clr_ovf    synchronous clear of the overrun flag
//   sample     current sample (registered, stable while done=1)
//   done       sample valid (registered)
//   overrun    sticky: a tick arrived while the previous sample was unacknowledged
module wave_sample_gen #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned ACC_W = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic [ACC_W-1:0] phase_inc,
    input  logic [1:0]       wave_sel,
    input  logic             ready,
    input  logic             clr_ovf,
    output logic [7:0]       sample,
    output logic             done,
    output logic             overrun
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    // IDLE: no sample outstanding; HOLD: sample offered, awaiting ready
    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [ACC_W-1:0] phase, phase_nx;
    logic [7:0]       sample_nx;
    logic             ovf_nx;
    logic             tick_c;
    logic [7:0]       p_c;
    logic [7:0]       wave_c;

    assign tick_c = en && (cnt == CNT_MAX);

    // Waveform is taken from the phase before this tick's increment
    assign p_c = phase[ACC_W-1 -: 8];

    // Sample shaping for the selected waveform
    always_comb begin
        wave_c = 8'h80;
        case (wave_sel)
            2'b00:   wave_c = p_c[7] ? 8'hFF : 8'h00;
            2'b01:   wave_c = p_c;
            2'b10:   wave_c = p_c[7] ? ~{p_c[6:0], 1'b0} : {p_c[6:0], 1'b0};
            default: wave_c = 8'h80;
        endcase
    end

    // Next-state: tick counter, phase accumulator, handshake and overrun
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        phase_nx  = phase;
        sample_nx = sample;
        ovf_nx    = overrun;

        if (!en || cnt == CNT_MAX) begin
            cnt_nx = '0;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end

        // Phase advances on every tick, even if the sample is dropped
        if (tick_c) begin
            phase_nx = phase + phase_inc;
        end

        // Clear first so that a simultaneous overrun set wins
        if (clr_ovf) begin
            ovf_nx = 1'b0;
        end

        case (state)
            S_IDLE: begin
                if (tick_c) begin
                    sample_nx = wave_c;
                    state_nx  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (tick_c) begin
                    // Ack at the tick edge consumes old and loads new back-to-back
                    if (ready) begin
                        sample_nx = wave_c;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end else if (ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            phase   <= '0;
            sample  <= 8'h00;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            phase   <= phase_nx;
            sample  <= sample_nx;
            done    <= (state_nx == S_HOLD);
            overrun <= ovf_nx;
        end
    end

endmodule
